gac_id_ex_ctrl_reg: RTL and testbench
=====================================

Name: gac_id_ex_ctrl_reg

Overview:
Pipeline register that captures the decoded control word from the decode-stage PLA OR plane and presents it to the execute stage one cycle later. Supports hold (stall), flush with multi-cycle bubble insertion, and a valid bit per slot. Drives a hold request back to IF/ID while bubbles are being inserted. Sits directly downstream of the control PLA in the pipelined MIPS datapath.

Parameters:
CTRL_W, 9, control word width: reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op[1:0].
FLUSH_CYC, 1, number of bubble cycles inserted per flush; legal range 1..7.
CNT_W, 3, bubble counter width; must hold FLUSH_CYC-1.

Ports:
clk  in  1  pipeline clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
ctrl_d  in  CTRL_W  control word from the PLA OR plane (combinational).
in_valid  in  1  decode slot holds a real instruction.
stall  in  1  hazard-unit hold request; freeze this stage.
flush  in  1  branch/jump flush request; start bubble insertion.
ctrl_q  out  CTRL_W  registered control word to EX.
valid_q  out  1  EX slot holds a real instruction.
id_hold  out  1  combinational; IF/ID must not advance.
bubble_active  out  1  combinational; bubble counter non-zero.

Behaviour:
- Reset: ctrl_q=0, valid_q=0, bubble counter=0. id_hold=0 and bubble_active=0 unless stall is high.
- Priority at each edge, highest first: rst, flush, bubble counter≠0, stall, load.
- flush: ctrl_q<=0, valid_q<=0, counter<=FLUSH_CYC-1. A flush during active bubbles reloads the counter; bubbles do not accumulate.
- Counter≠0, no flush: ctrl_q<=0, valid_q<=0, counter decrements. Stall is ignored while bubbling.
- stall, counter=0, no flush: ctrl_q and valid_q hold their values.
- load: ctrl_q<=ctrl_d gated by in_valid (all-zero when in_valid=0); valid_q<=in_valid.
- Latency: one cycle from ctrl_d to ctrl_q.
- id_hold = stall | (counter≠0). bubble_active = (counter≠0).
- FLUSH_CYC=1: a flush inserts exactly one bubble; the counter never leaves 0.
- All-zero control word is the NOP encoding. It writes nothing and accesses no memory.
- rst mid-bubble clears the counter immediately. The next edge after rst deasserts is a normal load.

Optional Feature:
Macro GAC_CTRL_PARITY_EN.
- Defined:
  - Adds a stored even-parity bit computed over ctrl_d at load.
  - Bubbles store parity 0.
  - Parity is recomputed on ctrl_q every cycle. A mismatch while valid_q=1 sets output ctrl_perr, which is sticky until rst.
  - Reset value of ctrl_perr is 0.
  - A test-only input perr_inject flips the stored parity bit on load.
- Not defined: no parity bit, no ctrl_perr or perr_inject ports. Behaviour is otherwise identical.

Decomposition:
- Package gac_ctrl_pkg holds:
  - CTRL_W;
  - bit-index constants for each control field (REG_DST..ALU_OP_HI);
  - CTRL_NOP (all-zero word);
  - the alu_op encodings shared with the PLA.
- One natural sub-module: gac_ctrl_bubble_cnt. It is a CNT_W-bit down-counter with synchronous load, decrement-to-zero and active flag. It is instanced once.

Test Plan:
- rst=1 for 2 cycles with ctrl_d=9'h1FF, in_valid=1 -> ctrl_q=0, valid_q=0, id_hold=0.
- Load ctrl_d=9'h0A5, in_valid=1 -> next edge ctrl_q=0x0A5, valid_q=1. Then in_valid=0 -> ctrl_q=0, valid_q=0.
- Load 0x0A5, then stall=1 for 3 cycles with ctrl_d=0x15A -> ctrl_q stays 0x0A5 and id_hold=1 throughout. Stall drops -> ctrl_q=0x15A.
- FLUSH_CYC=3: flush for one cycle -> ctrl_q=0 and valid_q=0 for 3 edges, id_hold=1 for 2 cycles after the flush edge. Then loading resumes.
- FLUSH_CYC=3: flush and stall together, then a second flush during the bubble -> counter reloads to 2, total bubbles = 1 + 3. Stall is ignored while bubbling.
- With GAC_CTRL_PARITY_EN: perr_inject on load of 0x003 -> ctrl_perr=1 after that edge and stays 1 across later clean loads until rst.

Source files
------------

// File: rtl/gac_ctrl_pkg.sv
// Shared definitions for the ID/EX control pipeline register.
// Control word layout, NOP encoding and the alu_op codes used by the
// decode-stage PLA.
package gac_ctrl_pkg;

    localparam int CTRL_W = 9;

    // Bit positions of each field inside the control word.
    localparam int REG_DST    = 0;
    localparam int ALU_SRC    = 1;
    localparam int MEM_TO_REG = 2;
    localparam int REG_WRITE  = 3;
    localparam int MEM_READ   = 4;
    localparam int MEM_WRITE  = 5;
    localparam int BRANCH     = 6;
    localparam int ALU_OP_LO  = 7;
    localparam int ALU_OP_HI  = 8;

    // All-zero word: no register write, no memory access, no branch.
    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_RTYPE = 2'b10,
        ALU_OP_RSVD  = 2'b11
    } alu_op_e;

    // Even-parity bit: makes the total count of ones (word + bit) even.
    function automatic logic ctrl_parity(input logic [CTRL_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/gac_ctrl_bubble_cnt.sv
// Bubble down-counter: synchronous load, decrement toward zero, and an
// active flag that is high whenever the count is non-zero.
module gac_ctrl_bubble_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             active
);

    // Counter state: reset clears, load has priority over decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    // Active flag follows the registered count.
    always_comb begin
        active = (count != '0);
    end

endmodule

// File: rtl/gac_id_ex_ctrl_reg.sv
// ID/EX control-word pipeline register.
// Captures the decoded control word one cycle after the PLA, supports
// stall (hold), flush with multi-cycle bubble insertion, and drives a
// hold request back to IF/ID while bubbles are in flight.
// Optional parity protection of the stored word: define GAC_CTRL_PARITY_EN.
module gac_id_ex_ctrl_reg
    import gac_ctrl_pkg::*;
#(
    parameter int CTRL_W    = gac_ctrl_pkg::CTRL_W,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic              valid_q,
    output logic              id_hold,
    output logic              bubble_active
`ifdef GAC_CTRL_PARITY_EN
    ,
    input  logic              perr_inject,
    output logic              ctrl_perr
`endif
);

    // Reload value: the flush edge itself is the first bubble, so the
    // counter only has to cover the remaining FLUSH_CYC-1 bubbles.
    localparam logic [CNT_W-1:0] BUBBLE_RELOAD = CNT_W'(FLUSH_CYC - 1);

    logic [CNT_W-1:0]  bubble_cnt;
    logic              bubbling;
    logic [CTRL_W-1:0] ctrl_gated;
    logic              do_load;

    gac_ctrl_bubble_cnt #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (flush),
        .load_val (BUBBLE_RELOAD),
        .count    (bubble_cnt),
        .active   (bubbling)
    );

    // Load-path word and load qualifier: invalid slots carry a NOP.
    always_comb begin
        ctrl_gated = in_valid ? ctrl_d : CTRL_W'(CTRL_NOP);
        do_load    = !flush && !bubbling && !stall;
    end

    // Pipeline register: flush and active bubbles both write a NOP;
    // a stall only freezes the stage when no bubble is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush || bubbling) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else if (do_load) begin
            ctrl_q  <= ctrl_gated;
            valid_q <= in_valid;
        end
    end

    // Hold request back to IF/ID and bubble status.
    always_comb begin
        id_hold       = stall | bubbling;
        bubble_active = bubbling;
    end

`ifdef GAC_CTRL_PARITY_EN
    logic par_q;
    logic perr_sticky;
    logic par_mismatch;

    // Stored parity bit tracks ctrl_q; bubbles store 0 to match the NOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (flush || bubbling) begin
            par_q <= 1'b0;
        end else if (do_load) begin
            par_q <= ctrl_parity(ctrl_gated) ^ perr_inject;
        end
    end

    // Live parity check on the registered word, only meaningful for real slots.
    always_comb begin
        par_mismatch = valid_q && (ctrl_parity(ctrl_q) != par_q);
        ctrl_perr    = perr_sticky | par_mismatch;
    end

    // Error latch: once seen, the error stays until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_sticky <= 1'b0;
        end else if (par_mismatch) begin
            perr_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gac_id_ex_ctrl_reg.sv
// Self-checking bench for gac_id_ex_ctrl_reg: one instance with three
// bubble cycles per flush and one with the single-bubble default.
module tb_gac_id_ex_ctrl_reg;

    localparam int W = 9;

    logic         clk;
    logic         rst;
    logic [W-1:0] ctrl_d;
    logic         in_valid;
    logic         stall;
    logic         flush;
    logic         perr_inject;

    logic [W-1:0] ctrl_q3, ctrl_q1;
    logic         valid_q3, valid_q1;
    logic         id_hold3, id_hold1;
    logic         bub3, bub1;
    logic         perr3, perr1;

    int n_checks = 0;
    int n_fail   = 0;

    gac_id_ex_ctrl_reg #(
        .CTRL_W    (W),
        .FLUSH_CYC (3),
        .CNT_W     (3)
    ) dut3 (
        .clk           (clk),
        .rst           (rst),
        .ctrl_d        (ctrl_d),
        .in_valid      (in_valid),
        .stall         (stall),
        .flush         (flush),
        .ctrl_q        (ctrl_q3),
        .valid_q       (valid_q3),
        .id_hold       (id_hold3),
        .bubble_active (bub3)
`ifdef GAC_CTRL_PARITY_EN
        ,
        .perr_inject   (perr_inject),
        .ctrl_perr     (perr3)
`endif
    );

    gac_id_ex_ctrl_reg #(
        .CTRL_W    (W),
        .FLUSH_CYC (1),
        .CNT_W     (3)
    ) dut1 (
        .clk           (clk),
        .rst           (rst),
        .ctrl_d        (ctrl_d),
        .in_valid      (in_valid),
        .stall         (stall),
        .flush         (flush),
        .ctrl_q        (ctrl_q1),
        .valid_q       (valid_q1),
        .id_hold       (id_hold1),
        .bubble_active (bub1)
`ifdef GAC_CTRL_PARITY_EN
        ,
        .perr_inject   (perr_inject),
        .ctrl_perr     (perr1)
`endif
    );

`ifndef GAC_CTRL_PARITY_EN
    assign perr3 = 1'b0;
    assign perr1 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [W-1:0] d;
        logic         v;
        logic         stall;
        logic         flush;
        logic [W-1:0] e_ctrl;
        logic         e_valid;
        logic         e_hold;
        logic         e_bub;
    } vec_t;

    localparam int NV = 17;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [W-1:0] d, input logic v,
                         input logic s, input logic f, input logic inj);
        rst         = r;
        ctrl_d      = d;
        in_valid    = v;
        stall       = s;
        flush       = f;
        perr_inject = inj;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          rst  d       v     stall flush e_ctrl  e_v   e_hold e_bub
        vec[0]  = '{1'b1, 9'h1FF, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0};
        vec[1]  = '{1'b1, 9'h1FF, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0};
        vec[2]  = '{1'b0, 9'h0A5, 1'b1, 1'b0, 1'b0, 9'h0A5, 1'b1, 1'b0, 1'b0};
        vec[3]  = '{1'b0, 9'h0A5, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0};
        vec[4]  = '{1'b0, 9'h0A5, 1'b1, 1'b0, 1'b0, 9'h0A5, 1'b1, 1'b0, 1'b0};
        vec[5]  = '{1'b0, 9'h15A, 1'b1, 1'b1, 1'b0, 9'h0A5, 1'b1, 1'b1, 1'b0};
        vec[6]  = '{1'b0, 9'h15A, 1'b1, 1'b1, 1'b0, 9'h0A5, 1'b1, 1'b1, 1'b0};
        vec[7]  = '{1'b0, 9'h15A, 1'b1, 1'b1, 1'b0, 9'h0A5, 1'b1, 1'b1, 1'b0};
        vec[8]  = '{1'b0, 9'h15A, 1'b1, 1'b0, 1'b0, 9'h15A, 1'b1, 1'b0, 1'b0};
        // single flush: three zero edges, hold for two cycles after the flush edge
        vec[9]  = '{1'b0, 9'h0C3, 1'b1, 1'b0, 1'b1, 9'h000, 1'b0, 1'b1, 1'b1};
        vec[10] = '{1'b0, 9'h0C3, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b1};
        vec[11] = '{1'b0, 9'h0C3, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0};
        vec[12] = '{1'b0, 9'h0C3, 1'b1, 1'b0, 1'b0, 9'h0C3, 1'b1, 1'b0, 1'b0};
        // flush+stall, re-flush during bubble, stall ignored while bubbling
        vec[13] = '{1'b0, 9'h111, 1'b1, 1'b1, 1'b1, 9'h000, 1'b0, 1'b1, 1'b1};
        vec[14] = '{1'b0, 9'h111, 1'b1, 1'b1, 1'b1, 9'h000, 1'b0, 1'b1, 1'b1};
        vec[15] = '{1'b0, 9'h111, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 1'b1, 1'b1};
        vec[16] = '{1'b0, 9'h111, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0};

        drive(1'b1, 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            drive(vec[i].rst, vec[i].d, vec[i].v, vec[i].stall, vec[i].flush, 1'b0);
            tick();
            chk($sformatf("v%0d ctrl_q", i),  32'(ctrl_q3),  32'(vec[i].e_ctrl));
            chk($sformatf("v%0d valid_q", i), 32'(valid_q3), 32'(vec[i].e_valid));
            chk($sformatf("v%0d id_hold", i), 32'(id_hold3), 32'(vec[i].e_hold));
            chk($sformatf("v%0d bubble", i),  32'(bub3),     32'(vec[i].e_bub));
        end

        // Stall released after the bubbles: loading resumes.
        drive(1'b0, 9'h111, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("resume ctrl_q", 32'(ctrl_q3), 32'h111);
        chk("resume valid_q", 32'(valid_q3), 32'h1);

        // Single-bubble instance: flush inserts exactly one bubble, no hold.
        drive(1'b0, 9'h055, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("fc1 pre ctrl_q", 32'(ctrl_q1), 32'h055);
        drive(1'b0, 9'h077, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("fc1 flush ctrl_q", 32'(ctrl_q1), 32'h000);
        chk("fc1 flush valid_q", 32'(valid_q1), 32'h0);
        chk("fc1 flush bubble", 32'(bub1), 32'h0);
        chk("fc1 flush id_hold", 32'(id_hold1), 32'h0);
        chk("fc3 flush bubble", 32'(bub3), 32'h1);
        drive(1'b0, 9'h077, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("fc1 after ctrl_q", 32'(ctrl_q1), 32'h077);
        chk("fc1 after valid_q", 32'(valid_q1), 32'h1);
        chk("fc3 still bubbling ctrl_q", 32'(ctrl_q3), 32'h000);
        chk("fc3 still bubbling", 32'(bub3), 32'h1);

        // Reset in the middle of a bubble clears the counter at once.
        drive(1'b1, 9'h077, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rst mid bubble", 32'(bub3), 32'h0);
        chk("rst mid id_hold", 32'(id_hold3), 32'h0);
        chk("rst mid ctrl_q", 32'(ctrl_q3), 32'h000);
        drive(1'b0, 9'h01A, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("post rst load ctrl_q", 32'(ctrl_q3), 32'h01A);
        chk("post rst load valid_q", 32'(valid_q3), 32'h1);

        // Stall with no bubble pending asserts hold combinationally.
        drive(1'b0, 9'h100, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("stall comb id_hold", 32'(id_hold3), 32'h1);
        tick();
        chk("stall hold ctrl_q", 32'(ctrl_q3), 32'h01A);

`ifdef GAC_CTRL_PARITY_EN
        drive(1'b0, 9'h003, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("clean load perr", 32'(perr3), 32'h0);
        drive(1'b0, 9'h003, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("inject perr", 32'(perr3), 32'h1);
        chk("inject perr fc1", 32'(perr1), 32'h1);
        drive(1'b0, 9'h0A5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("sticky perr", 32'(perr3), 32'h1);
        drive(1'b1, 9'h0A5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rst clears perr", 32'(perr3), 32'h0);
`else
        chk("no parity perr tie", 32'(perr3 | perr1), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
